// File: rtl/regfile_pkg.sv
// Shared constants, address-width helper and default-configuration types
// for the integer register file and its busy scoreboard.
package regfile_pkg;

    localparam int REG_ZERO = 0;
    localparam int REG_A0   = 10;

    function automatic int addr_w(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

    typedef logic [4:0]  reg_addr_t;
    typedef logic [31:0] reg_data_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: tracks outstanding producers, grants
// destination reservations and reports operand readiness to decode.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int REG_COUNT = 32,
    parameter int NUM_WR    = 2,
    parameter int NUM_RD    = 2,
    parameter int BYPASS    = 1,
    localparam int AW       = addr_w(REG_COUNT)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_WR-1:0]    we,
    input  logic [NUM_WR*AW-1:0] wr_addr,
    input  logic [NUM_RD*AW-1:0] rd_addr,
    input  logic                 issue_valid,
    input  logic [AW-1:0]        issue_rd,
    output logic                 issue_ready,
    output logic [NUM_RD-1:0]    rd_busy
);
    logic [REG_COUNT-1:0] busy_q;
    logic [REG_COUNT-1:0] busy_d;
    logic [REG_COUNT-1:0] clear_vec_s;
    logic [REG_COUNT-1:0] set_vec_s;
    logic                 issue_ready_s;

    // Writebacks retire producers; a reservation on a register retiring this cycle is accepted.
    always_comb begin
        clear_vec_s = '0;
        for (int i = 0; i < NUM_WR; i++) begin
            clear_vec_s[wr_addr[i*AW +: AW]] = clear_vec_s[wr_addr[i*AW +: AW]] | we[i];
        end
        clear_vec_s[REG_ZERO] = 1'b0;

        issue_ready_s = !(busy_q[issue_rd] && !clear_vec_s[issue_rd]);

        set_vec_s           = '0;
        set_vec_s[issue_rd] = issue_valid & issue_ready_s;
        set_vec_s[REG_ZERO] = 1'b0;

        busy_d           = (busy_q & ~clear_vec_s) | set_vec_s;
        busy_d[REG_ZERO] = 1'b0;
    end

    // Busy vector state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Operand readiness; with forwarding, a retiring producer already counts as ready.
    always_comb begin
        rd_busy = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            rd_busy[p] = (BYPASS != 0)
                       ? (busy_q[rd_addr[p*AW +: AW]] && !clear_vec_s[rd_addr[p*AW +: AW]])
                       : busy_q[rd_addr[p*AW +: AW]];
        end
    end

    assign issue_ready = issue_ready_s;

endmodule

// File: rtl/register_file_sb.sv
// Multi-port integer register file with write-priority mux, optional
// same-cycle write-to-read forwarding and an integrated busy scoreboard.
module register_file_sb
    import regfile_pkg::*;
#(
    parameter int REG_COUNT = 32,
    parameter int REG_WIDTH = 32,
    parameter int NUM_RD    = 2,
    parameter int NUM_WR    = 2,
    parameter int BYPASS    = 1,
    parameter int A0_IDX    = REG_A0,
    localparam int AW       = addr_w(REG_COUNT)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_RD*AW-1:0]        rd_addr,
    output logic [NUM_RD*REG_WIDTH-1:0] rd_data,
    output logic [NUM_RD-1:0]           rd_busy,
    input  logic [NUM_WR-1:0]           we,
    input  logic [NUM_WR*AW-1:0]        wr_addr,
    input  logic [NUM_WR*REG_WIDTH-1:0] wr_data,
    input  logic                        issue_valid,
    input  logic [AW-1:0]               issue_rd,
    output logic                        issue_ready,
    output logic [REG_WIDTH-1:0]        a0
);
    logic [REG_WIDTH-1:0] regs_q [REG_COUNT];
    logic [REG_WIDTH-1:0] regs_d [REG_COUNT];
    logic [AW-1:0]        ra_s;
    logic [REG_WIDTH-1:0] rval_s;

    // Next storage state; ports are applied in ascending order so the highest index wins.
    always_comb begin
        regs_d = regs_q;
        for (int i = 0; i < NUM_WR; i++) begin
            regs_d[wr_addr[i*AW +: AW]] = we[i] ? wr_data[i*REG_WIDTH +: REG_WIDTH]
                                                : regs_d[wr_addr[i*AW +: AW]];
        end
        regs_d[REG_ZERO] = '0;
    end

    // Architectural register storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < REG_COUNT; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read ports: stored value, optionally overridden by the highest-priority matching write.
    always_comb begin
        rd_data = '0;
        ra_s    = '0;
        rval_s  = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            ra_s   = rd_addr[p*AW +: AW];
            rval_s = regs_q[ra_s];
            for (int j = 0; j < NUM_WR; j++) begin
                rval_s = ((BYPASS != 0) && we[j] && (wr_addr[j*AW +: AW] == ra_s))
                       ? wr_data[j*REG_WIDTH +: REG_WIDTH] : rval_s;
            end
            rd_data[p*REG_WIDTH +: REG_WIDTH] = (ra_s == AW'(REG_ZERO)) ? '0 : rval_s;
        end
    end

    assign a0 = regs_q[A0_IDX];

    regfile_scoreboard #(
        .REG_COUNT (REG_COUNT),
        .NUM_WR    (NUM_WR),
        .NUM_RD    (NUM_RD),
        .BYPASS    (BYPASS)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .we          (we),
        .wr_addr     (wr_addr),
        .rd_addr     (rd_addr),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_ready (issue_ready),
        .rd_busy     (rd_busy)
    );

endmodule

// File: tb/tb_register_file_sb.sv
// Scoreboard bench: drives a forwarding and a non-forwarding register file in
// lockstep and checks both against a behavioural register/busy model.
module tb_register_file_sb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  rd_addr = '0;
    logic [1:0]  we = '0;
    logic [9:0]  wr_addr = '0;
    logic [63:0] wr_data = '0;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_rd = '0;

    logic [63:0] rd_data1, rd_data0;
    logic [1:0]  rd_busy1, rd_busy0;
    logic        issue_ready1, issue_ready0;
    logic [31:0] a0_1, a0_0;

    always #5 clk = ~clk;

    register_file_sb #(.BYPASS(1)) dut1 (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_busy(rd_busy1),
        .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .issue_valid(issue_valid),
        .issue_rd(issue_rd), .issue_ready(issue_ready1), .a0(a0_1)
    );

    register_file_sb #(.BYPASS(0)) dut0 (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data0), .rd_busy(rd_busy0),
        .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .issue_valid(issue_valid),
        .issue_rd(issue_rd), .issue_ready(issue_ready0), .a0(a0_0)
    );

    typedef struct packed {
        int          step;
        logic [63:0] rdata1;
        logic [63:0] rdata0;
        logic [1:0]  busy1;
        logic [1:0]  busy0;
        logic        ready;
        logic [31:0] a0;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mem_m [32];
    logic [31:0] busy_m;
    int          checks = 0;
    int          failures = 0;
    int          step = 0;

    task automatic chk(input string nm, input int st, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s step=%0d actual=%h required=%h", nm, st, act, req);
        end
    endtask

    function automatic void model_reset();
        for (int r = 0; r < 32; r++) mem_m[r] = 32'h0;
        busy_m = 32'h0;
    endfunction

    // True when some enabled write port targets non-zero register a this cycle.
    function automatic logic hit(input logic [4:0] a);
        return (a != 5'd0) && ((we[1] && wr_addr[9:5] == a) || (we[0] && wr_addr[4:0] == a));
    endfunction

    function automatic logic [31:0] fwd(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (we[1] && wr_addr[9:5] == a) return wr_data[63:32];
        if (we[0] && wr_addr[4:0] == a) return wr_data[31:0];
        return mem_m[a];
    endfunction

    function automatic void commit(input logic granted);
        if (we[1] && wr_addr[9:5] != 5'd0) mem_m[wr_addr[9:5]] = wr_data[63:32];
        if (we[0] && wr_addr[4:0] != 5'd0 && !(we[1] && wr_addr[9:5] == wr_addr[4:0]))
            mem_m[wr_addr[4:0]] = wr_data[31:0];
        for (int r = 1; r < 32; r++) if (hit(5'(r))) busy_m[r] = 1'b0;
        if (issue_valid && granted && issue_rd != 5'd0) busy_m[issue_rd] = 1'b1;
    endfunction

    task automatic drive(input logic [1:0] w, input logic [4:0] wa1, input logic [4:0] wa0,
                         input logic [31:0] wd1, input logic [31:0] wd0,
                         input logic [4:0] ra1, input logic [4:0] ra0,
                         input logic iv, input logic [4:0] ird);
        exp_t e;
        @(posedge clk);
        #1;
        we = w; wr_addr = {wa1, wa0}; wr_data = {wd1, wd0};
        rd_addr = {ra1, ra0}; issue_valid = iv; issue_rd = ird;
        e.step   = step;
        e.rdata1 = {fwd(ra1), fwd(ra0)};
        e.rdata0 = {mem_m[ra1], mem_m[ra0]};
        e.busy1  = {busy_m[ra1] && !hit(ra1), busy_m[ra0] && !hit(ra0)};
        e.busy0  = {busy_m[ra1], busy_m[ra0]};
        e.ready  = !(busy_m[ird] && !hit(ird));
        e.a0     = mem_m[10];
        exp_q.push_back(e);
        commit(e.ready);
        step++;
    endtask

    task automatic idle(input logic [4:0] ra1, input logic [4:0] ra0);
        drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, ra1, ra0, 1'b0, 5'd0);
    endtask

    task automatic rand_cycle();
        drive(2'($urandom_range(0, 3)), 5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)),
              $urandom, $urandom, 5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)),
              1'($urandom_range(0, 1)), 5'($urandom_range(0, 15)));
    endtask

    // Monitor: every cycle with an outstanding expectation is compared on the falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("rdata_byp",   e.step, rd_data1,             e.rdata1);
            chk("rdata_nobyp", e.step, rd_data0,             e.rdata0);
            chk("busy_byp",    e.step, 64'(rd_busy1),        64'(e.busy1));
            chk("busy_nobyp",  e.step, 64'(rd_busy0),        64'(e.busy0));
            chk("ready_byp",   e.step, 64'(issue_ready1),    64'(e.ready));
            chk("ready_nobyp", e.step, 64'(issue_ready0),    64'(e.ready));
            chk("a0_byp",      e.step, 64'(a0_1),            64'(e.a0));
            chk("a0_nobyp",    e.step, 64'(a0_0),            64'(e.a0));
        end
    end

    initial begin
        model_reset();
        rd_addr = {5'd10, 5'd5};
        issue_rd = 5'd3;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_rdata",  -1, rd_data1 | rd_data0, 64'h0);
        chk("reset_busy",   -1, 64'({rd_busy1, rd_busy0}), 64'h0);
        chk("reset_ready",  -1, 64'({issue_ready1, issue_ready0}), 64'h3);
        chk("reset_a0",     -1, 64'({a0_1, a0_0}), 64'h0);

        drive(2'b11, 5'd5, 5'd5, 32'hBBBB, 32'hAAAA, 5'd5, 5'd5, 1'b0, 5'd0);
        @(negedge clk);
        chk("prio_byp",      step, 64'(rd_data1[31:0]), 64'h0000_BBBB);
        chk("prio_nobyp",    step, 64'(rd_data0[31:0]), 64'h0);
        drive(2'b01, 5'd0, 5'd0, 32'h0, 32'hFFFF, 5'd5, 5'd0, 1'b0, 5'd0);
        @(negedge clk);
        chk("x0_byp",        step, 64'(rd_data1[31:0]), 64'h0);
        chk("x0_nobyp",      step, 64'(rd_data0[31:0]), 64'h0);
        chk("prio_commit",   step, 64'(rd_data0[63:32]), 64'h0000_BBBB);
        drive(2'b01, 5'd0, 5'd7, 32'h0, 32'h1234, 5'd7, 5'd7, 1'b0, 5'd0);
        @(negedge clk);
        chk("bypass_same",   step, 64'(rd_data1[31:0]), 64'h1234);
        chk("nobyp_old",     step, 64'(rd_data0[31:0]), 64'h0);
        drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd7, 5'd7, 1'b1, 5'd3);
        @(negedge clk);
        chk("nobyp_next",    step, 64'(rd_data0[31:0]), 64'h1234);
        chk("issue3_ready",  step, 64'(issue_ready1), 64'h1);
        drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd3, 5'd3, 1'b1, 5'd3);
        @(negedge clk);
        chk("busy3",         step, 64'(rd_busy1[0]), 64'h1);
        chk("waw_block",     step, 64'(issue_ready1), 64'h0);
        drive(2'b01, 5'd0, 5'd3, 32'h0, 32'h33, 5'd3, 5'd3, 1'b0, 5'd0);
        @(negedge clk);
        chk("wb_byp_busy",   step, 64'(rd_busy1[0]), 64'h0);
        chk("wb_nobyp_busy", step, 64'(rd_busy0[0]), 64'h1);
        idle(5'd3, 5'd3);
        @(negedge clk);
        chk("busy3_cleared", step, 64'({rd_busy1[0], rd_busy0[0]}), 64'h0);
        drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd9);
        drive(2'b10, 5'd9, 5'd0, 32'h99, 32'h0, 5'd9, 5'd9, 1'b1, 5'd9);
        @(negedge clk);
        chk("setclr_ready",  step, 64'({issue_ready1, issue_ready0}), 64'h3);
        idle(5'd9, 5'd9);
        @(negedge clk);
        chk("setclr_busy",   step, 64'({rd_busy1[0], rd_busy0[0]}), 64'h3);
        chk("setclr_data",   step, 64'(rd_data0[31:0]), 64'h99);
        drive(2'b01, 5'd0, 5'd10, 32'h0, 32'hDEADBEEF, 5'd10, 5'd0, 1'b0, 5'd0);
        @(negedge clk);
        chk("a0_same",       step, 64'(a0_1), 64'h0);
        chk("a0_byp_read",   step, 64'(rd_data1[63:32]), 64'hDEADBEEF);
        idle(5'd0, 5'd0);
        @(negedge clk);
        chk("a0_next",       step, 64'({a0_1, a0_0}), {32'hDEADBEEF, 32'hDEADBEEF});

        for (int n = 0; n < 400; n++) rand_cycle();

        drive(2'b01, 5'd0, 5'd6, 32'h0, 32'hCAFE, 5'd6, 5'd6, 1'b1, 5'd6);
        idle(5'd6, 5'd10);
        @(negedge clk);
        chk("preload_busy6", step, 64'(rd_busy0[1]), 64'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rdata",   step, rd_data1 | rd_data0, 64'h0);
        chk("async_busy",    step, 64'({rd_busy1, rd_busy0}), 64'h0);
        chk("async_ready",   step, 64'({issue_ready1, issue_ready0}), 64'h3);
        chk("async_a0",      step, 64'({a0_1, a0_0}), 64'h0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int n = 0; n < 40; n++) rand_cycle();
        idle(5'd0, 5'd0);
        @(negedge clk);
        @(negedge clk);
        chk("queue_drain", step, 64'(exp_q.size()), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
